// File: rtl/mult_div_if.sv
// Handshake and HI/LO bus between the MIPS datapath and the iterative multiply/divide unit.
// The datapath drives the master side and the unit implements the slave side.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             hiW;
  logic             loW;
  logic [WIDTH-1:0] writeData;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opA, opB, hiW, loW, writeData,
    input  busy, done, divZero, hi, lo
  );

  modport slave (
    input  start, op, opA, opB, hiW, loW, writeData,
    output busy, done, divZero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Uses a shift-add multiplier and a restoring divider on operand magnitudes; signs are applied in FIX.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_div_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {product high, multiplier} or {unused, quotient}
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rmd;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    mag_a   = (bus.op[0] && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
    mag_b   = (bus.op[0] && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
    shifted = {rem_q, acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, opnd_q};
    prod    = res_neg_q ? -acc_q : acc_q;
    quo     = res_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rmd     = rem_neg_q ? -rem_q : rem_q;

    // mthi/mtlo only land while idle; a result written later in the same op wins.
    if (!busy_q && bus.hiW) hi_d = bus.writeData;
    if (!busy_q && bus.loW) lo_d = bus.writeData;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d    = 1'b1;
          cnt_d     = CW'(WIDTH);
          is_div_d  = bus.op[1];
          res_neg_d = bus.op[0] & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
          rem_neg_d = bus.op[0] & bus.op[1] & bus.opA[WIDTH-1];
          rem_d     = '0;
          if (bus.op[1]) begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            opnd_d  = mag_b;
            state_d = (bus.opB == '0) ? S_DONE : S_RUN;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            opnd_d  = mag_a;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          // Restoring step: keep the trial difference only when it did not go negative.
          rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rmd;
          lo_d = quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        div_zero_d = 1'b0;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      S_DONE: begin
        div_zero_d = 1'b1;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divZero = div_zero_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table vectors, hand-written corner sequences,
// and randomized operations compared against an arithmetic reference model of HI/LO/divZero.
module tb_mult_div_unit;
  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural result.
  task automatic model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    if (op[1] && b == '0) begin
      m_dz = 1'b1;
      return;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: p = {32'b0, a} * {32'b0, b};
      2'b01: p = sa * sb;
      2'b10: p = {a % b, a / b};
      default: begin
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
    endcase
    m_dz = 1'b0;
    m_hi = p[63:32];
    m_lo = p[31:0];
  endtask

  // Called at a falling edge; the following rising edge is the launch edge.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic hw, input logic lw, input logic [W-1:0] wd);
    bus.start = 1'b1;
    bus.op = op;
    bus.opA = a;
    bus.opB = b;
    bus.hiW = hw;
    bus.loW = lw;
    bus.writeData = wd;
    if (hw) m_hi = wd;
    if (lw) m_lo = wd;
    model_op(op, a, b);
    @(negedge clk);
    bus.start = 1'b0;
    bus.hiW = 1'b0;
    bus.loW = 1'b0;
    bus.op = 2'($urandom);
    bus.opA = $urandom;
    bus.opB = $urandom;
    check("launch_busy", bus.busy, 1);
    check("launch_done", bus.done, 0);
  endtask

  task automatic wait_done(input int start_at, input int low_at, output int lat);
    int k = 0;
    int busy_n = 1;
    while (!bus.done && k < 100) begin
      bus.start = (k == start_at);
      if (k == start_at) begin
        bus.op = 2'b00;
        bus.opA = 9;
        bus.opB = 9;
      end
      bus.loW = (k == low_at);
      if (k == low_at) bus.writeData = 32'hAAAA;
      @(negedge clk);
      k++;
      if (bus.busy && !bus.done) busy_n++;
    end
    bus.start = 1'b0;
    bus.loW = 1'b0;
    lat = k;
    check("busy_cycles", busy_n, lat);
    check("busy_at_done", bus.busy, 0);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic hw, input logic lw,
                     input logic [W-1:0] wd, input int start_at, input int low_at);
    int lat;
    launch(op, a, b, hw, lw, wd);
    wait_done(start_at, low_at, lat);
    check({name, "_latency"}, lat, (op[1] && b == '0) ? 1 : W + 1);
    check({name, "_hi"}, bus.hi, m_hi);
    check({name, "_lo"}, bus.lo, m_lo);
    check({name, "_divZero"}, bus.divZero, m_dz);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
    vecs[5] = '{2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.opA = '0;
    bus.opB = '0;
    bus.hiW = 1'b0;
    bus.loW = 1'b0;
    bus.writeData = '0;

    #12;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_divZero", bus.divZero, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, '0, -1, -1);
      check($sformatf("vec%0d_tbl_hi", i), bus.hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_tbl_lo", i), bus.lo, vecs[i].exp_lo);
      check($sformatf("vec%0d_tbl_dz", i), bus.divZero, vecs[i].exp_dz);
    end

    // Divide by zero leaves preloaded HI/LO intact; the next good op clears divZero.
    @(negedge clk);
    bus.hiW = 1'b1;
    bus.writeData = 32'h1234;
    @(negedge clk);
    bus.hiW = 1'b0;
    bus.loW = 1'b1;
    bus.writeData = 32'h5678;
    @(negedge clk);
    bus.loW = 1'b0;
    m_hi = 32'h1234;
    m_lo = 32'h5678;
    check("preload_hi", bus.hi, 32'h1234);
    check("preload_lo", bus.lo, 32'h5678);
    run("div_zero", 2'b11, 32'd5, 32'd0, 1'b0, 1'b0, '0, -1, -1);
    check("div_zero_hi_kept", bus.hi, 32'h1234);
    run("after_dz", 2'b00, 32'd2, 32'd3, 1'b0, 1'b0, '0, -1, -1);
    check("after_dz_lo6", bus.lo, 32'd6);

    // Overflow divide with an ignored start and a dropped mtlo while busy.
    run("ovf_interlock", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 5, 10);
    check("ovf_lo", bus.lo, 32'h8000_0000);
    @(negedge clk);
    check("ovf_no_relaunch", bus.busy, 0);

    // Asynchronous reset in the middle of a multiply.
    launch(2'b00, 32'h1234, 32'h5678, 1'b0, 1'b0, '0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_hi", bus.hi, 0);
    check("midrst_lo", bus.lo, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_divZero", bus.divZero, 0);
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run("post_rst", 2'b00, 32'd7, 32'd6, 1'b0, 1'b0, '0, -1, -1);

    // mthi on the launch edge applies, then the product overwrites it.
    launch(2'b00, 32'd1, 32'd1, 1'b1, 1'b0, 32'hBEEF);
    check("same_edge_hi", bus.hi, 32'hBEEF);
    begin
      int lat;
      wait_done(-1, -1, lat);
      check("same_edge_latency", lat, W + 1);
      check("same_edge_res_hi", bus.hi, 0);
      check("same_edge_res_lo", bus.lo, 1);
    end

    // Randomized back-to-back operations with occasional same-edge HI/LO writes.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 50)) : W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: rb = W'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      run($sformatf("rnd%0d", i), rop, ra, rb, ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), $urandom, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
